// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; drains queued bytes as back-to-back frames.
// data_ready is combinational (!full); tx is registered and idles high.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 86,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned NW = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [7:0]           mem_d [FIFO_DEPTH];
  logic                 push, pop, bit_end, not_empty;

  assign data_ready = (count_q != NW'(FIFO_DEPTH));
  assign push       = data_valid && data_ready;
  assign not_empty  = (count_q != '0);
  assign bit_end    = (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || not_empty;

  // Frame sequencer; pop decisions use the registered count only
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and storage
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
